// File: rtl/elevator_controller.sv
// Five-floor collective elevator controller: latches hall and car calls, sweeps up/down
// with timed floor travel and door dwell, and drives request LEDs plus a seven-segment status.
module elevator_controller #(
    parameter int FLOOR_TICKS = 100,
    parameter int DOOR_TICKS  = 150
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       floor_0_p,
    input  logic       floor_1_p,
    input  logic       floor_2_p,
    input  logic       floor_3_p,
    input  logic       floor_4_p,
    input  logic       direction_1,
    input  logic       direction_2,
    input  logic       direction_3,
    input  logic       floor_0_d,
    input  logic       floor_1_d,
    input  logic       floor_2_d,
    input  logic       floor_3_d,
    input  logic       floor_4_d,
    output logic       led_inside_0,
    output logic       led_inside_1,
    output logic       led_inside_2,
    output logic       led_inside_3,
    output logic       led_inside_4,
    output logic       led_outside_0,
    output logic       led_outside_1,
    output logic       led_outside_2,
    output logic       led_outside_3,
    output logic       led_outside_4,
    output logic       led_busy,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic [7:0] c,
    output logic [7:0] d,
    output logic [7:0] e,
    output logic [7:0] f,
    output logic [7:0] g,
    output logic [7:0] p
);
    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TICK_W    = $clog2(MAX_TICKS + 1);
    localparam logic [TICK_W-1:0] FLOOR_LAST = TICK_W'(FLOOR_TICKS - 1);
    localparam logic [TICK_W-1:0] DOOR_LAST  = TICK_W'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

    state_t            state_q, state_d;
    logic [2:0]        curFloor_q, curFloor_d;
    logic              dirUp_q, dirUp_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [4:0]        carReq_q, carReq_d, hallUp_q, hallUp_d, hallDn_q, hallDn_d;

    logic [4:0] hallBtn, carBtn, upSel, latchEn, curOneHot, nextOneHot, allReq;
    logic [4:0] hallUpSet, hallDnSet, carSet, carClr, upClr, dnClr;
    logic [2:0] nextFloor, upDist, dnDist;
    logic       curPress, pickUp, stopHere;
    logic [6:0] seg0, seg1;

    // Floors strictly beyond fl in the given direction.
    function automatic logic [4:0] aheadMask(input logic [2:0] fl, input logic up);
        logic [4:0] above, below;
        above = 5'b11110 << fl;
        below = (5'b00001 << fl) - 5'b00001;
        return up ? above : below;
    endfunction

    function automatic logic [6:0] digitSegs(input logic [2:0] fl);
        case (fl)
            3'd0:    return 7'b1111110;
            3'd1:    return 7'b0110000;
            3'd2:    return 7'b1101101;
            3'd3:    return 7'b1111001;
            3'd4:    return 7'b0110011;
            default: return 7'b0000000;
        endcase
    endfunction

    assign hallBtn    = {floor_4_p, floor_3_p, floor_2_p, floor_1_p, floor_0_p};
    assign carBtn     = {floor_4_d, floor_3_d, floor_2_d, floor_1_d, floor_0_d};
    assign upSel      = {1'b0, direction_3, direction_2, direction_1, 1'b1};
    assign curOneHot  = 5'b00001 << curFloor_q;
    assign nextOneHot = 5'b00001 << nextFloor;
    assign latchEn    = (state_q == MOVING) ? 5'b11111 : ~curOneHot;
    assign hallUpSet  = hallBtn & upSel & latchEn;
    assign hallDnSet  = hallBtn & ~upSel & latchEn;
    assign carSet     = carBtn & latchEn;
    assign allReq     = carReq_q | hallUp_q | hallDn_q;
    assign curPress   = (state_q != MOVING) && (((hallBtn | carBtn) & curOneHot) != 5'b0);

    // Nearest pending request on each side; 7 marks "none", so an empty side never wins.
    always_comb begin
        upDist = 3'd7;
        dnDist = 3'd7;
        for (int i = 4; i >= 0; i--) begin
            if (allReq[3'(i)] && (3'(i) > curFloor_q)) upDist = 3'(i) - curFloor_q;
        end
        for (int i = 0; i <= 4; i++) begin
            if (allReq[3'(i)] && (3'(i) < curFloor_q)) dnDist = curFloor_q - 3'(i);
        end
        pickUp = (upDist <= dnDist);
    end

    always_comb begin
        nextFloor = curFloor_q;
        if (dirUp_q && (curFloor_q < 3'd4)) nextFloor = curFloor_q + 3'd1;
        else if (!dirUp_q && (curFloor_q > 3'd0)) nextFloor = curFloor_q - 3'd1;
    end

    assign stopHere = (|(carReq_q & nextOneHot))
                   || (dirUp_q ? (|(hallUp_q & nextOneHot)) : (|(hallDn_q & nextOneHot)))
                   || ((|((hallUp_q | hallDn_q) & nextOneHot))
                       && ((allReq & aheadMask(nextFloor, dirUp_q)) == 5'b0))
                   || (nextFloor == 3'd0) || (nextFloor == 3'd4);

    always_comb begin
        state_d    = state_q;
        curFloor_d = curFloor_q;
        dirUp_d    = dirUp_q;
        tick_d     = tick_q;
        carClr     = 5'b0;
        upClr      = 5'b0;
        dnClr      = 5'b0;
        case (state_q)
            IDLE: begin
                if (curPress) begin
                    state_d = DOOR_OPEN;
                    tick_d  = '0;
                end else if (allReq != 5'b0) begin
                    state_d = MOVING;
                    tick_d  = '0;
                    dirUp_d = pickUp;
                end
            end
            MOVING: begin
                if (tick_q == FLOOR_LAST) begin
                    tick_d     = '0;
                    curFloor_d = nextFloor;
                    if (stopHere) begin
                        state_d = DOOR_OPEN;
                        carClr  = nextOneHot;
                        if (dirUp_q) upClr = nextOneHot;
                        else         dnClr = nextOneHot;
                        if ((allReq & aheadMask(nextFloor, dirUp_q)) == 5'b0) begin
                            upClr = nextOneHot;
                            dnClr = nextOneHot;
                        end
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            DOOR_OPEN: begin
                if (curPress) begin
                    tick_d = '0;
                end else if (tick_q == DOOR_LAST) begin
                    tick_d = '0;
                    if ((allReq & aheadMask(curFloor_q, dirUp_q)) != 5'b0) begin
                        state_d = MOVING;
                    end else if ((allReq & aheadMask(curFloor_q, !dirUp_q)) != 5'b0) begin
                        state_d = MOVING;
                        dirUp_d = !dirUp_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Clears are applied after sets so a stop beats a press at the same floor.
        carReq_d = (carReq_q | carSet) & ~carClr;
        hallUp_d = (hallUp_q | hallUpSet) & ~upClr;
        hallDn_d = (hallDn_q | hallDnSet) & ~dnClr;
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q    <= IDLE;
            curFloor_q <= 3'd0;
            dirUp_q    <= 1'b1;
            tick_q     <= '0;
            carReq_q   <= 5'b0;
            hallUp_q   <= 5'b0;
            hallDn_q   <= 5'b0;
        end else begin
            state_q    <= state_d;
            curFloor_q <= curFloor_d;
            dirUp_q    <= dirUp_d;
            tick_q     <= tick_d;
            carReq_q   <= carReq_d;
            hallUp_q   <= hallUp_d;
            hallDn_q   <= hallDn_d;
        end
    end

    assign {led_inside_4, led_inside_3, led_inside_2, led_inside_1, led_inside_0} = carReq_q;
    assign {led_outside_4, led_outside_3, led_outside_2, led_outside_1, led_outside_0} =
        hallUp_q | hallDn_q;
    assign led_busy = (state_q != IDLE);

    // Segment order is abcdefg, active-high here and inverted onto the pins.
    assign seg0 = digitSegs(curFloor_q);
    assign seg1 = (state_q == MOVING) ? (dirUp_q ? 7'b0111110 : 7'b0111101) : 7'b0000001;

    assign a = {6'h3F, ~seg1[6], ~seg0[6]};
    assign b = {6'h3F, ~seg1[5], ~seg0[5]};
    assign c = {6'h3F, ~seg1[4], ~seg0[4]};
    assign d = {6'h3F, ~seg1[3], ~seg0[3]};
    assign e = {6'h3F, ~seg1[2], ~seg0[2]};
    assign f = {6'h3F, ~seg1[1], ~seg0[1]};
    assign g = {6'h3F, ~seg1[0], ~seg0[0]};
    assign p = 8'hFF;
endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: each stimulus pushes timed expectations,
// a negedge monitor pops and compares them as the cycle count reaches them.
module tb_elevator_controller;
    localparam int FT = 4;
    localparam int DT = 6;

    // Active-low digit patterns packed as {a,b,c,d,e,f,g}.
    localparam logic [63:0] SEG0  = 64'b0000001;
    localparam logic [63:0] SEG1  = 64'b1001111;
    localparam logic [63:0] SEG2  = 64'b0010010;
    localparam logic [63:0] SEG3  = 64'b0000110;
    localparam logic [63:0] SEG4  = 64'b1001100;
    localparam logic [63:0] SEGU  = 64'b1000001;
    localparam logic [63:0] SEGD  = 64'b1000010;
    localparam logic [63:0] DASH  = 64'b1111110;
    localparam logic [63:0] BLANK = (64'd1 << 50) - 64'd1;

    typedef enum int {F_DIG0, F_DIG1, F_IN, F_OUT, F_BUSY, F_BLANK} field_t;
    typedef struct {
        int          at;
        string       tag;
        field_t      fld;
        logic [63:0] exp;
    } item_t;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hallIn = 5'b0;
    logic [4:0] carIn = 5'b0;
    logic [3:1] dirIn = 3'b0;
    logic [4:0] ledInside, ledOutside;
    logic       ledBusy;
    logic [7:0] segA, segB, segC, segD, segE, segF, segG, segP;

    item_t sb[$];
    int    cyc = 0;
    int    lastAt = 0;
    int    compared = 0;
    int    mismatched = 0;
    int    ev, ev2;

    elevator_controller #(.FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
        .clk_in(clk_in), .rst(rst),
        .floor_0_p(hallIn[0]), .floor_1_p(hallIn[1]), .floor_2_p(hallIn[2]),
        .floor_3_p(hallIn[3]), .floor_4_p(hallIn[4]),
        .direction_1(dirIn[1]), .direction_2(dirIn[2]), .direction_3(dirIn[3]),
        .floor_0_d(carIn[0]), .floor_1_d(carIn[1]), .floor_2_d(carIn[2]),
        .floor_3_d(carIn[3]), .floor_4_d(carIn[4]),
        .led_inside_0(ledInside[0]), .led_inside_1(ledInside[1]), .led_inside_2(ledInside[2]),
        .led_inside_3(ledInside[3]), .led_inside_4(ledInside[4]),
        .led_outside_0(ledOutside[0]), .led_outside_1(ledOutside[1]),
        .led_outside_2(ledOutside[2]), .led_outside_3(ledOutside[3]),
        .led_outside_4(ledOutside[4]),
        .led_busy(ledBusy),
        .a(segA), .b(segB), .c(segC), .d(segD), .e(segE), .f(segF), .g(segG), .p(segP)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] observe(input field_t fld);
        case (fld)
            F_DIG0:  return 64'({segA[0], segB[0], segC[0], segD[0], segE[0], segF[0], segG[0]});
            F_DIG1:  return 64'({segA[1], segB[1], segC[1], segD[1], segE[1], segF[1], segG[1]});
            F_IN:    return 64'(ledInside);
            F_OUT:   return 64'(ledOutside);
            F_BUSY:  return 64'(ledBusy);
            F_BLANK: return 64'({segA[7:2], segB[7:2], segC[7:2], segD[7:2], segE[7:2],
                                 segF[7:2], segG[7:2], segP});
            default: return 64'd0;
        endcase
    endfunction

    task automatic expectAt(input int at, input string tag, input field_t fld, input logic [63:0] exp);
        item_t it;
        it.at  = at;
        it.tag = tag;
        it.fld = fld;
        it.exp = exp;
        sb.push_back(it);
        if (at > lastAt) lastAt = at;
    endtask

    // Pop every expectation due at this cycle; outputs are stable half a period after the edge.
    always @(negedge clk_in) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                checkOutput(sb[i].tag, observe(sb[i].fld), sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic idleUntil(input int n);
        while (cyc < n) begin
            @(negedge clk_in);
            #1;
        end
    endtask

    // Drives buttons so they are sampled at edge evN; endStimulus releases them one edge later.
    task automatic applyStimulus(input logic [4:0] hall, input logic [3:1] dirs,
                                 input logic [4:0] car, output int evN);
        hallIn = hall;
        dirIn  = dirs;
        carIn  = car;
        evN    = cyc + 1;
    endtask

    task automatic applyReset(output int evN);
        rst = 1'b0;
        evN = cyc + 1;
    endtask

    task automatic endStimulus();
        @(negedge clk_in);
        #1;
        hallIn = 5'b0;
        carIn  = 5'b0;
        rst    = 1'b1;
    endtask

    task automatic expectResetState(input int at, input string tag);
        expectAt(at, {tag, " dig0"}, F_DIG0, SEG0);
        expectAt(at, {tag, " dig1"}, F_DIG1, DASH);
        expectAt(at, {tag, " busy"}, F_BUSY, 64'd0);
        expectAt(at, {tag, " inside"}, F_IN, 64'd0);
        expectAt(at, {tag, " outside"}, F_OUT, 64'd0);
    endtask

    initial begin
        @(negedge clk_in);
        #1;

        applyReset(ev);
        expectResetState(ev, "reset");
        expectAt(ev, "reset blank", F_BLANK, BLANK);
        endStimulus();
        idleUntil(lastAt + 1);

        // Single car call to floor 3.
        applyStimulus(5'b00000, 3'b000, 5'b01000, ev);
        expectAt(ev, "car3 led", F_IN, 64'b01000);
        expectAt(ev, "car3 idle", F_BUSY, 64'd0);
        expectAt(ev + 1, "car3 busy", F_BUSY, 64'd1);
        expectAt(ev + 1, "car3 up", F_DIG1, SEGU);
        expectAt(ev + FT, "car3 still0", F_DIG0, SEG0);
        expectAt(ev + 1 + FT, "car3 fl1", F_DIG0, SEG1);
        expectAt(ev + 3 * FT, "car3 fl2", F_DIG0, SEG2);
        expectAt(ev + 1 + 3 * FT, "car3 fl3", F_DIG0, SEG3);
        expectAt(ev + 1 + 3 * FT, "car3 cleared", F_IN, 64'd0);
        expectAt(ev + 1 + 3 * FT, "car3 door", F_DIG1, DASH);
        expectAt(ev + 3 * FT + DT, "car3 dwell", F_BUSY, 64'd1);
        expectAt(ev + 1 + 3 * FT + DT, "car3 idle end", F_BUSY, 64'd0);
        endStimulus();
        idleUntil(lastAt + 1);

        // Collective up sweep: hall 4, then hall 2 going up.
        applyReset(ev);
        expectResetState(ev, "rst2");
        endStimulus();
        applyStimulus(5'b10000, 3'b000, 5'b00000, ev);
        expectAt(ev, "coll out4", F_OUT, 64'b10000);
        endStimulus();
        applyStimulus(5'b00100, 3'b010, 5'b00000, ev2);
        expectAt(ev2, "coll out42", F_OUT, 64'b10100);
        expectAt(ev2, "coll busy", F_BUSY, 64'd1);
        expectAt(ev + 1 + FT, "coll pass1", F_DIG1, SEGU);
        expectAt(ev + 2 * FT, "coll fl1", F_DIG0, SEG1);
        expectAt(ev + 1 + 2 * FT, "coll fl2", F_DIG0, SEG2);
        expectAt(ev + 1 + 2 * FT, "coll clr2", F_OUT, 64'b10000);
        expectAt(ev + 1 + 2 * FT, "coll door2", F_DIG1, DASH);
        expectAt(ev + 2 * FT + DT, "coll dwell2", F_DIG1, DASH);
        expectAt(ev + 1 + 2 * FT + DT, "coll resume", F_DIG1, SEGU);
        expectAt(ev + 1 + 3 * FT + DT, "coll fl3", F_DIG0, SEG3);
        expectAt(ev + 1 + 4 * FT + DT, "coll fl4", F_DIG0, SEG4);
        expectAt(ev + 1 + 4 * FT + DT, "coll clr4", F_OUT, 64'd0);
        expectAt(ev + 4 * FT + 2 * DT, "coll dwell4", F_BUSY, 64'd1);
        expectAt(ev + 1 + 4 * FT + 2 * DT, "coll idle", F_BUSY, 64'd0);
        endStimulus();
        idleUntil(lastAt + 1);

        // Down call at 1 raised after passing it; served after reversing at 4.
        applyReset(ev);
        expectResetState(ev, "rst3");
        endStimulus();
        applyStimulus(5'b10000, 3'b000, 5'b00000, ev);
        endStimulus();
        idleUntil(ev + 1 + 2 * FT);
        applyStimulus(5'b00010, 3'b000, 5'b00000, ev2);
        expectAt(ev2, "opp out", F_OUT, 64'b10010);
        expectAt(ev + 1 + 3 * FT, "opp fl3 up", F_DIG0, SEG3);
        expectAt(ev + 1 + 3 * FT, "opp dir up", F_DIG1, SEGU);
        expectAt(ev + 1 + 4 * FT, "opp fl4", F_DIG0, SEG4);
        expectAt(ev + 1 + 4 * FT, "opp clr4", F_OUT, 64'b00010);
        expectAt(ev + 1 + 4 * FT, "opp door4", F_DIG1, DASH);
        expectAt(ev + 1 + 4 * FT + DT, "opp reverse", F_DIG1, SEGD);
        expectAt(ev + 1 + 5 * FT + DT, "opp fl3 dn", F_DIG0, SEG3);
        expectAt(ev + 1 + 6 * FT + DT, "opp fl2 dn", F_DIG0, SEG2);
        expectAt(ev + 1 + 7 * FT + DT, "opp fl1", F_DIG0, SEG1);
        expectAt(ev + 1 + 7 * FT + DT, "opp clr1", F_OUT, 64'd0);
        expectAt(ev + 1 + 7 * FT + DT, "opp door1", F_DIG1, DASH);
        expectAt(ev + 1 + 7 * FT + 2 * DT, "opp idle", F_BUSY, 64'd0);
        endStimulus();
        idleUntil(lastAt + 1);

        // Same-floor presses open the door and restart the dwell.
        applyReset(ev);
        expectResetState(ev, "rst4");
        endStimulus();
        applyStimulus(5'b00000, 3'b000, 5'b00001, ev);
        expectAt(ev, "same noled", F_IN, 64'd0);
        expectAt(ev, "same busy", F_BUSY, 64'd1);
        expectAt(ev, "same door", F_DIG1, DASH);
        endStimulus();
        idleUntil(ev + 2);
        applyStimulus(5'b00001, 3'b000, 5'b00000, ev2);
        expectAt(ev2, "same nohall", F_OUT, 64'd0);
        expectAt(ev + DT, "same restart", F_BUSY, 64'd1);
        expectAt(ev2 + DT - 1, "same dwell", F_BUSY, 64'd1);
        expectAt(ev2 + DT, "same idle", F_BUSY, 64'd0);
        expectAt(ev2 + DT, "same floor0", F_DIG0, SEG0);
        endStimulus();
        idleUntil(lastAt + 1);

        // Simultaneous presses latch together; reset lands between floors 2 and 3.
        applyReset(ev);
        expectResetState(ev, "rst5");
        endStimulus();
        applyStimulus(5'b01010, 3'b100, 5'b10000, ev);
        expectAt(ev, "multi inside", F_IN, 64'b10000);
        expectAt(ev, "multi outside", F_OUT, 64'b01010);
        expectAt(ev + 1 + FT, "multi pass1", F_DIG0, SEG1);
        expectAt(ev + 1 + FT, "multi nostop1", F_DIG1, SEGU);
        expectAt(ev + 1 + 2 * FT, "multi pass2", F_DIG1, SEGU);
        expectAt(ev + 2 + 2 * FT, "multi busy", F_BUSY, 64'd1);
        endStimulus();
        idleUntil(ev + 2 + 2 * FT);
        applyReset(ev2);
        expectResetState(ev2, "midreset");
        expectResetState(ev2 + FT, "midreset hold");
        endStimulus();
        idleUntil(lastAt + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
